equation_sequencer: RTL and testbench
=====================================

Name: equation_sequencer

Overview:
- Game-rule sequencer that sits downstream of the collision controller.
- Consumes its one-per-frame number-hit pulses and operand-hit pulses and walks the player through "number, operand, number".
- Evaluates the equation against the current target value and drives score, lives, respawn and game-over signals to the display and object logic.
- Owns all ordering, timeout and win/lose decisions, so the collision logic stays purely detective.

Parameters:
- NUMBERS, 3, count of number objects; width of the hit and respawn vectors.
- VAL_W, 4, bit width of each number value and of the target.
- TIMEOUT_FRAMES, 300, frames allowed in WAIT_OP or WAIT_SECOND before the attempt fails (about 10 s at 30 Hz).
- RESULT_FRAMES, 45, frames the RESULT state holds for on-screen feedback.
- START_LIVES, 3, lives loaded at reset.
- SCORE_W, 8, width of the score counter.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset, sampled on the rising edge of clk.
- startOfFrame, in, 1, one-cycle pulse at the start of each frame.
- SingleHitPulse, in, NUMBERS, one-cycle pulse per number hit.
- operandHit, in, 2, one-cycle pulse; bit 0 = plus, bit 1 = minus.
- numberValues, in, NUMBERS*VAL_W, packed value of each number object; index i at bits [i*VAL_W +: VAL_W].
- targetValue, in, VAL_W, current target; sampled in EVAL.
- phase, out, 3, current state encoding, for HUD and debug.
- firstValue, out, VAL_W, latched first operand.
- opSelect, out, 1, latched operator; 0 = plus, 1 = minus.
- resultValue, out, VAL_W+2, signed two's-complement result of the last evaluation.
- successPulse, out, 1, one-cycle pulse on a correct equation.
- failPulse, out, 1, one-cycle pulse on a wrong equation or a timeout.
- respawnMask, out, NUMBERS, one-cycle pulse requesting respawn of the consumed numbers.
- score, out, SCORE_W, saturating count of successes.
- lives, out, 3, remaining lives.
- gameOver, out, 1, level signal asserted while in GAME_OVER.

Behaviour:
- Reset values:
  - State is WAIT_FIRST.
  - firstValue, opSelect, resultValue, score, and all pulse outputs are 0.
  - lives = START_LIVES; gameOver = 0.
  - The internal frame counter and the latched indices are cleared.
- Reset has priority over every other event in the same cycle, including reset asserted mid-RESULT or mid-timeout.
- States are WAIT_FIRST, WAIT_OP, WAIT_SECOND, EVAL, RESULT and GAME_OVER.
- WAIT_FIRST:
  - On any SingleHitPulse bit, latch the index (the lowest set bit wins if several are set) and firstValue = numberValues[idx].
  - Go to WAIT_OP and clear the frame counter.
  - operandHit is ignored here.
- WAIT_OP:
  - On operandHit != 0, latch opSelect: plus wins if both bits are set. Go to WAIT_SECOND and clear the frame counter.
  - Number hits are ignored here.
- WAIT_SECOND:
  - On a SingleHitPulse bit, latch the second index and value and go to EVAL.
  - A hit on the same index as the first number is accepted; the same number may be used twice.
  - Operand hits are ignored.
- Timeout (WAIT_OP and WAIT_SECOND):
  - The frame counter increments on each startOfFrame.
  - When it reaches TIMEOUT_FRAMES, assert failPulse, decrement lives and go to RESULT.
  - A valid hit in the same cycle as the timeout wins; no fail is raised.
- EVAL (exactly 1 cycle):
  - Compute resultValue = first ± second, sign-extended to VAL_W+2.
  - Match condition: the result equals the zero-extended targetValue. A negative result never matches.
  - On a match: successPulse = 1, score + 1 saturating at 2^SCORE_W − 1, and respawnMask pulses both consumed indices.
  - On no match: failPulse = 1, lives − 1, and respawnMask = 0.
  - Go to RESULT and clear the frame counter.
- Latency:
  - The success or fail pulse is asserted in the cycle after EVAL is entered, i.e. 2 clk cycles after the second hit pulse.
  - A timeout fail is asserted 1 cycle after the counter reaches its terminal value.
- RESULT:
  - Hold RESULT_FRAMES frames, counted on startOfFrame.
  - Then go to WAIT_FIRST, or to GAME_OVER if lives == 0.
  - All hits are ignored during RESULT.
- GAME_OVER:
  - gameOver = 1; all inputs are ignored.
  - Leave only on reset.
- lives never underflows; a decrement when lives is already 0 is impossible by construction, but the RTL must guard against it.
- All pulse outputs are registered and last exactly one cycle.

Decomposition:
- Package eq_seq_pkg holds:
  - the state enum with a 3-bit encoding;
  - the OP_PLUS/OP_MINUS constants;
  - a function that returns the lowest set index of a NUMBERS-bit vector.
- One natural sub-module, frame_timer: a startOfFrame-driven counter with clear input, load-limit input and done output. It is shared by the timeout and RESULT hold logic.

Test Plan:
- Success path: reset; hit idx0 (val 3), plus, hit idx2 (val 4), target 7 -> successPulse 2 cycles later, resultValue 7, score 1, respawnMask 3'b101; after 45 frames, phase = WAIT_FIRST.
- Minus with negative result: 2 − 5, target 0 -> resultValue −3 (0x3D at 6 bits), failPulse, lives 2, respawnMask 0.
- Ignored inputs: operand hit in WAIT_FIRST and number hit in WAIT_OP -> no state change; simultaneous SingleHitPulse 3'b110 in WAIT_FIRST -> idx1 latched; operandHit 2'b11 -> plus.
- Timeout: first number only, then 300 startOfFrame pulses -> failPulse on the 300th frame + 1 cycle, lives decremented; a number hit on that same cycle -> no fail, EVAL entered.
- Game over: three consecutive fails -> lives 0, gameOver = 1 after RESULT hold; further hits have no effect; reset -> lives 3, score 0, phase = WAIT_FIRST.
- Reset mid-RESULT and score saturation at 255 with SCORE_W = 8 -> reset values restored in the next cycle; score holds at 255 on further successes.

Source files
------------

// File: rtl/eq_seq_pkg.sv
// Shared state encoding, operator codes and index helper
// for the equation sequencer.
package eq_seq_pkg;

    typedef enum logic [2:0] {
        S_WAIT_FIRST  = 3'd0,
        S_WAIT_OP     = 3'd1,
        S_WAIT_SECOND = 3'd2,
        S_EVAL        = 3'd3,
        S_RESULT      = 3'd4,
        S_GAME_OVER   = 3'd5
    } state_t;

    localparam logic OP_PLUS  = 1'b0;
    localparam logic OP_MINUS = 1'b1;

    localparam int MAX_NUMBERS = 32;

    // Lowest set bit wins when several objects are hit in one frame.
    function automatic int lowest_index(input logic [MAX_NUMBERS-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_NUMBERS - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame counter that saturates at a loadable limit; shared by
// the attempt timeout and the result hold.
module frame_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count < limit)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count >= limit);

endmodule

// File: rtl/equation_sequencer.sv
// Game-rule sequencer: number, operand, number, then score or
// lose a life against the current target.
module equation_sequencer
    import eq_seq_pkg::*;
#(
    parameter int NUMBERS        = 3,
    parameter int VAL_W          = 4,
    parameter int TIMEOUT_FRAMES = 300,
    parameter int RESULT_FRAMES  = 45,
    parameter int START_LIVES    = 3,
    parameter int SCORE_W        = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic [NUMBERS-1:0]       SingleHitPulse,
    input  logic [1:0]               operandHit,
    input  logic [NUMBERS*VAL_W-1:0] numberValues,
    input  logic [VAL_W-1:0]         targetValue,
    output logic [2:0]               phase,
    output logic [VAL_W-1:0]         firstValue,
    output logic                     opSelect,
    output logic [VAL_W+1:0]         resultValue,
    output logic                     successPulse,
    output logic                     failPulse,
    output logic [NUMBERS-1:0]       respawnMask,
    output logic [SCORE_W-1:0]       score,
    output logic [2:0]               lives,
    output logic                     gameOver
);

    localparam int IDX_W = (NUMBERS > 1) ? $clog2(NUMBERS) : 1;
    localparam int RES_W = VAL_W + 2;
    localparam int T_MAX = (TIMEOUT_FRAMES > RESULT_FRAMES)
                         ? TIMEOUT_FRAMES : RESULT_FRAMES;
    localparam int TMR_W = $clog2(T_MAX + 1);

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]       first_idx;
    logic [IDX_W-1:0]       second_idx;
    logic [IDX_W-1:0]       hit_idx;
    logic [VAL_W-1:0]       second_value;
    logic [VAL_W-1:0]       hit_value;
    logic [MAX_NUMBERS-1:0] hit_ext;
    logic                   hit_any;
    logic                   op_any;
    logic                   timer_done;
    logic                   timer_clear;
    logic [TMR_W-1:0]       timer_limit;
    logic                   latch_first;
    logic                   latch_op;
    logic                   latch_second;
    logic                   timeout;
    logic                   win;
    logic                   lose;
    logic [RES_W-1:0]       first_ext;
    logic [RES_W-1:0]       second_ext;
    logic [RES_W-1:0]       eval_value;
    logic [RES_W-1:0]       target_ext;
    logic [NUMBERS-1:0]     consumed;

    assign hit_any   = |SingleHitPulse;
    assign op_any    = |operandHit;
    assign hit_ext   = MAX_NUMBERS'(SingleHitPulse);
    assign hit_idx   = IDX_W'(lowest_index(hit_ext));
    assign hit_value = numberValues[int'(hit_idx) * VAL_W +: VAL_W];

    // Any state change restarts the frame count for the new state.
    assign timer_clear = (state_next != state);
    assign timer_limit = (state == S_RESULT) ? TMR_W'(RESULT_FRAMES)
                                             : TMR_W'(TIMEOUT_FRAMES);

    frame_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .tick (startOfFrame),
        .clear(timer_clear),
        .limit(timer_limit),
        .done (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_WAIT_FIRST;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_WAIT_FIRST: begin
                if (hit_any) state_next = S_WAIT_OP;
            end
            S_WAIT_OP: begin
                if (op_any)          state_next = S_WAIT_SECOND;
                else if (timer_done) state_next = S_RESULT;
            end
            S_WAIT_SECOND: begin
                if (hit_any)         state_next = S_EVAL;
                else if (timer_done) state_next = S_RESULT;
            end
            S_EVAL: begin
                state_next = S_RESULT;
            end
            S_RESULT: begin
                if (timer_done)
                    state_next = (lives == 3'd0) ? S_GAME_OVER
                                                 : S_WAIT_FIRST;
            end
            S_GAME_OVER: begin
                state_next = S_GAME_OVER;
            end
            default: begin
                state_next = S_WAIT_FIRST;
            end
        endcase
    end

    always_comb begin
        latch_first  = 1'b0;
        latch_op     = 1'b0;
        latch_second = 1'b0;
        timeout      = 1'b0;
        unique case (state)
            S_WAIT_FIRST: begin
                latch_first = hit_any;
            end
            S_WAIT_OP: begin
                latch_op = op_any;
                timeout  = !op_any && timer_done;
            end
            S_WAIT_SECOND: begin
                latch_second = hit_any;
                timeout      = !hit_any && timer_done;
            end
            default: begin
            end
        endcase
    end

    assign first_ext  = RES_W'(firstValue);
    assign second_ext = RES_W'(second_value);
    assign target_ext = RES_W'(targetValue);
    assign eval_value = (opSelect == OP_MINUS) ? first_ext - second_ext
                                               : first_ext + second_ext;

    assign win  = (state == S_EVAL) && !eval_value[RES_W-1]
                && (eval_value == target_ext);
    assign lose = ((state == S_EVAL) && !win) || timeout;

    assign consumed = (NUMBERS'(1) << first_idx)
                    | (NUMBERS'(1) << second_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            first_idx    <= '0;
            second_idx   <= '0;
            firstValue   <= '0;
            second_value <= '0;
            opSelect     <= OP_PLUS;
            resultValue  <= '0;
            successPulse <= 1'b0;
            failPulse    <= 1'b0;
            respawnMask  <= '0;
            score        <= '0;
            lives        <= 3'(START_LIVES);
        end else begin
            successPulse <= win;
            failPulse    <= lose;
            respawnMask  <= win ? consumed : '0;
            if (latch_first) begin
                first_idx  <= hit_idx;
                firstValue <= hit_value;
            end
            if (latch_op) begin
                opSelect <= operandHit[0] ? OP_PLUS : OP_MINUS;
            end
            if (latch_second) begin
                second_idx   <= hit_idx;
                second_value <= hit_value;
            end
            if (state == S_EVAL) begin
                resultValue <= eval_value;
            end
            if (win && (score != {SCORE_W{1'b1}})) begin
                score <= score + 1'b1;
            end
            if (lose && (lives != 3'd0)) begin
                lives <= lives - 3'd1;
            end
        end
    end

    assign phase    = state;
    assign gameOver = (state == S_GAME_OVER);

endmodule

// File: tb/tb_equation_sequencer.sv
// Scoreboard bench for equation_sequencer: stimulus predicts each
// success/fail outcome, a negedge monitor checks it.
module tb_equation_sequencer;

    localparam int RESULT_FRAMES  = 45;
    localparam int TIMEOUT_FRAMES = 300;
    localparam int SCORE_MAX      = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [2:0]  SingleHitPulse = '0;
    logic [1:0]  operandHit = '0;
    logic [11:0] numberValues = '0;
    logic [3:0]  targetValue = '0;
    logic [2:0]  phase;
    logic [3:0]  firstValue;
    logic        opSelect;
    logic [5:0]  resultValue;
    logic        successPulse;
    logic        failPulse;
    logic [2:0]  respawnMask;
    logic [7:0]  score;
    logic [2:0]  lives;
    logic        gameOver;

    equation_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .SingleHitPulse(SingleHitPulse),
        .operandHit    (operandHit),
        .numberValues  (numberValues),
        .targetValue   (targetValue),
        .phase         (phase),
        .firstValue    (firstValue),
        .opSelect      (opSelect),
        .resultValue   (resultValue),
        .successPulse  (successPulse),
        .failPulse     (failPulse),
        .respawnMask   (respawnMask),
        .score         (score),
        .lives         (lives),
        .gameOver      (gameOver)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit         succ;
        logic [5:0] res;
        int         score;
        int         lives;
        logic [2:0] mask;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int n_checks = 0;
    int n_fail = 0;

    int         m_score;
    int         m_lives;
    logic [5:0] m_result;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    function automatic int lowest(input logic [2:0] v);
        int idx;
        bit found;
        idx = 0;
        found = 0;
        for (int i = 0; i < 3; i++) begin
            if (v[i] && !found) begin
                idx = i;
                found = 1;
            end
        end
        return idx;
    endfunction

    task automatic tick(input logic sof, input logic [2:0] hit,
                        input logic [1:0] op);
        startOfFrame   = sof;
        SingleHitPulse = hit;
        operandHit     = op;
        @(posedge clk);
        #1;
        startOfFrame   = 1'b0;
        SingleHitPulse = '0;
        operandHit     = '0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 3'b000, 2'b00);
            tick(1'b0, 3'b000, 2'b00);
        end
    endtask

    task automatic expect_eval(input int r, input logic [3:0] t,
                               input int ia, input int ib);
        exp_t x;
        bit match;
        logic [2:0] mask;
        match = (r >= 0) && (r == int'(t));
        mask = '0;
        if (match) begin
            mask[ia] = 1'b1;
            mask[ib] = 1'b1;
            if (m_score < SCORE_MAX) m_score++;
        end else if (m_lives > 0) begin
            m_lives--;
        end
        m_result = 6'(r);
        x.succ  = match;
        x.res   = m_result;
        x.score = m_score;
        x.lives = m_lives;
        x.mask  = match ? mask : 3'b000;
        x.cyc   = cyc + 1;
        exp_q.push_back(x);
    endtask

    task automatic expect_timeout();
        exp_t x;
        if (m_lives > 0) m_lives--;
        x.succ  = 1'b0;
        x.res   = m_result;
        x.score = m_score;
        x.lives = m_lives;
        x.mask  = 3'b000;
        x.cyc   = cyc + 1;
        exp_q.push_back(x);
    endtask

    task automatic reset_dut(input logic sof, input logic [2:0] hit,
                             input logic [1:0] op);
        check("queue_empty_at_reset", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        tick(sof, hit, op);
        reset = 1'b0;
        m_score  = 0;
        m_lives  = 3;
        m_result = '0;
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_first", 32'(firstValue), 32'd0);
        check("rst_op", 32'(opSelect), 32'd0);
        check("rst_result", 32'(resultValue), 32'd0);
        check("rst_gameover", 32'(gameOver), 32'd0);
        check("rst_pulses",
              32'({successPulse, failPulse, respawnMask}), 32'd0);
    endtask

    task automatic episode(input logic [11:0] v1, input logic [11:0] v2,
                           input logic [2:0] h1, input logic [1:0] op,
                           input logic [2:0] h2, input logic [3:0] tgt,
                           input bit model_tgt, input bit noise);
        int ia, ib, a, b, r;
        bit minus;
        logic [3:0] t;
        ia = lowest(h1);
        ib = lowest(h2);
        a = int'(v1[ia*4 +: 4]);
        b = int'(v2[ib*4 +: 4]);
        minus = !op[0];
        r = minus ? a - b : a + b;
        t = (model_tgt && r >= 0 && r <= 15) ? 4'(r) : tgt;
        numberValues = v1;
        if (noise) begin
            tick(1'b0, 3'b000, 2'b11);
            check("ignore_op_in_first", 32'(phase), 32'd0);
        end
        tick(1'b0, h1, 2'b00);
        check("phase_wait_op", 32'(phase), 32'd1);
        check("first_value", 32'(firstValue), 32'(a));
        numberValues = v2;
        if (noise) begin
            tick(1'b0, 3'b111, 2'b00);
            check("ignore_hit_in_op", 32'(phase), 32'd1);
            check("first_value_held", 32'(firstValue), 32'(a));
        end
        tick(1'b0, 3'b000, op);
        check("phase_wait_second", 32'(phase), 32'd2);
        check("op_select", 32'(opSelect), 32'(minus));
        if (noise) begin
            tick(1'b0, 3'b000, 2'b11);
            check("ignore_op_in_second", 32'(phase), 32'd2);
        end
        targetValue = t;
        tick(1'b0, h2, 2'b00);
        check("phase_eval", 32'(phase), 32'd3);
        expect_eval(r, t, ia, ib);
        tick(1'b0, 3'b000, 2'b00);
        frames(RESULT_FRAMES);
        check("phase_after_result", 32'(phase),
              (m_lives == 0) ? 32'd5 : 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (successPulse || failPulse) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got success=%0b fail=%0b, required none (t=%0t)",
                             successPulse, failPulse, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 32'({successPulse, failPulse}),
                          e.succ ? 32'd2 : 32'd1);
                    check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    check("result_value", 32'(resultValue), 32'(e.res));
                    check("score", 32'(score), 32'(e.score));
                    check("lives", 32'(lives), 32'(e.lives));
                    check("respawn_mask", 32'(respawnMask), 32'(e.mask));
                end
            end else if (respawnMask != 3'b000) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_respawn: got %0b, required 000 (t=%0t)",
                         respawnMask, $time);
            end
        end
    end

    initial begin
        m_score  = 0;
        m_lives  = 3;
        m_result = '0;
        tick(1'b0, 3'b000, 2'b00);
        reset_dut(1'b0, 3'b000, 2'b00);

        // 3 + 4 = 7
        episode(12'h493, 12'h493, 3'b001, 2'b01, 3'b100, 4'd7, 0, 0);
        check("success_result", 32'(resultValue), 32'd7);
        check("success_score", 32'(score), 32'd1);

        // 3'b110 latches idx1, 2'b11 is plus, same index reused
        episode(12'h061, 12'h020, 3'b110, 2'b11, 3'b010, 4'd8, 0, 1);

        // 2 - 5 = -3 never matches
        episode(12'h002, 12'h050, 3'b001, 2'b10, 3'b010, 4'd0, 0, 0);
        check("neg_result", 32'(resultValue), 32'h3D);
        check("neg_lives", 32'(lives), 32'd2);

        // Timeout in WAIT_OP
        numberValues = 12'h007;
        tick(1'b0, 3'b001, 2'b00);
        check("to_phase_op", 32'(phase), 32'd1);
        for (int i = 1; i <= TIMEOUT_FRAMES; i++) begin
            tick(1'b1, 3'b000, 2'b00);
            if (i == TIMEOUT_FRAMES) expect_timeout();
            else if (i == TIMEOUT_FRAMES - 1)
                check("to_not_early", 32'(phase), 32'd1);
            tick(1'b0, 3'b000, 2'b00);
        end
        check("to_phase_result", 32'(phase), 32'd4);
        check("to_lives", 32'(lives), 32'd1);
        frames(RESULT_FRAMES);
        check("to_back_first", 32'(phase), 32'd0);

        // Hit in the timeout cycle wins
        numberValues = 12'h030;
        tick(1'b0, 3'b010, 2'b00);
        tick(1'b0, 3'b000, 2'b01);
        check("tw_phase_second", 32'(phase), 32'd2);
        numberValues = 12'h005;
        targetValue = 4'd8;
        for (int i = 1; i < TIMEOUT_FRAMES; i++) begin
            tick(1'b1, 3'b000, 2'b00);
            tick(1'b0, 3'b000, 2'b00);
        end
        tick(1'b1, 3'b000, 2'b00);
        tick(1'b0, 3'b001, 2'b00);
        check("tw_hit_wins", 32'(phase), 32'd3);
        expect_eval(8, 4'd8, 1, 0);
        tick(1'b0, 3'b000, 2'b00);
        frames(10);
        check("tw_score", 32'(score), 32'd3);
        reset_dut(1'b1, 3'b111, 2'b11);

        // Three fails -> game over
        for (int k = 0; k < 3; k++)
            episode(12'h111, 12'h111, 3'b001, 2'b01, 3'b001, 4'd9, 0, 0);
        check("go_flag", 32'(gameOver), 32'd1);
        for (int k = 0; k < 20; k++) tick(1'b1, 3'b111, 2'b11);
        check("go_phase_held", 32'(phase), 32'd5);
        check("go_lives", 32'(lives), 32'd0);
        reset_dut(1'b0, 3'b000, 2'b00);

        // Random play
        for (int n = 0; n < 40; n++) begin
            episode(12'($urandom), 12'($urandom),
                    3'($urandom_range(1, 7)), 2'($urandom_range(1, 3)),
                    3'($urandom_range(1, 7)), 4'($urandom),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            if (m_lives == 0) begin
                check("rand_gameover", 32'(gameOver), 32'd1);
                for (int k = 0; k < 5; k++) tick(1'b1, 3'b101, 2'b01);
                reset_dut(1'b0, 3'b000, 2'b00);
            end
        end

        // Score saturation
        reset_dut(1'b0, 3'b000, 2'b00);
        for (int n = 0; n < SCORE_MAX + 3; n++) begin
            episode(12'($urandom) & 12'h777, 12'($urandom) & 12'h777,
                    3'($urandom_range(1, 7)), 2'b01,
                    3'($urandom_range(1, 7)), 4'd0, 1, 0);
        end
        check("sat_score", 32'(score), 32'd255);
        check("sat_lives", 32'(lives), 32'd3);
        reset_dut(1'b0, 3'b000, 2'b00);

        tick(1'b0, 3'b000, 2'b00);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
